// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF (IEC 60958 consumer) transmitter.
package spdif_pkg;

    // Preamble half-cell patterns, first half-cell in the MSB, for line level 0
    localparam logic [7:0] PREAMBLE_B = 8'b11101000;
    localparam logic [7:0] PREAMBLE_M = 8'b11100010;
    localparam logic [7:0] PREAMBLE_W = 8'b11100100;

    // Frame geometry
    localparam int SUBFRAME_HALFCELLS = 64;
    localparam int BLOCK_FRAMES       = 192;
    localparam int PREAMBLE_HALFCELLS = 8;

    localparam logic [5:0] HC_LAST    = 6'(SUBFRAME_HALFCELLS - 1);
    localparam logic [7:0] FRAME_LAST = 8'(BLOCK_FRAMES - 1);
    localparam logic [2:0] PHASE_LAST = 3'(PREAMBLE_HALFCELLS - 1);

    // Only the first 32 channel-status bits can be non-zero
    localparam logic [7:0] CS_DEFINED_FRAMES = 8'd32;

    // Copy permitted (bit 2) and 48 kHz sample-rate code (bit 25)
    localparam logic [31:0] DEFAULT_CHANNEL_STATUS = 32'h0200_0004;

    // Time-slot positions within a subframe
    localparam logic [4:0] SLOT_AUX_FIRST    = 5'd4;
    localparam logic [4:0] SLOT_SAMPLE_FIRST = 5'd12;
    localparam logic [4:0] SLOT_SAMPLE_LAST  = 5'd27;
    localparam logic [4:0] SLOT_VALIDITY     = 5'd28;
    localparam logic [4:0] SLOT_USER         = 5'd29;
    localparam logic [4:0] SLOT_CHSTAT       = 5'd30;
    localparam logic [4:0] SLOT_PARITY       = 5'd31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    typedef enum logic {
        SUB_LEFT  = 1'b0,
        SUB_RIGHT = 1'b1
    } subframe_t;

endpackage

// File: rtl/biphase_mark_encoder.sv
// Line coder: turns preamble patterns and data bits into biphase-mark half-cells.
// Owns the line level and the half-cell phase; knows nothing about framing.
module biphase_mark_encoder
    import spdif_pkg::*;
(
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Clk_Ena,
    input  logic       Clear,
    input  logic       Bit_Value,
    input  logic       Preamble,
    input  logic [7:0] Preamble_Pattern,
    output logic       Line_Out
);

    logic       line_level;
    logic [2:0] phase;
    logic       preamble_base;
    logic       base_now;
    logic       line_next;

    // Next line level: preamble half-cells are the pattern relative to the level at
    // subframe start; data cells toggle at cell start and again mid-cell for a 1.
    always_comb begin
        base_now  = (phase == 3'd0) ? line_level : preamble_base;
        line_next = line_level;
        if (Preamble) begin
            line_next = Preamble_Pattern[PHASE_LAST - phase] ^ base_now;
        end else if (!phase[0]) begin
            line_next = ~line_level;
        end else if (Bit_Value) begin
            line_next = ~line_level;
        end
    end

    // Line register, half-cell phase and the preamble reference level
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            line_level    <= 1'b0;
            phase         <= 3'd0;
            preamble_base <= 1'b0;
        end else if (Clear) begin
            line_level    <= 1'b0;
            phase         <= 3'd0;
            preamble_base <= 1'b0;
        end else if (Clk_Ena) begin
            line_level <= line_next;
            phase      <= phase + 3'd1;
            if (Preamble && (phase == 3'd0)) begin
                preamble_base <= line_level;
            end
        end
    end

    assign Line_Out = line_level;

endmodule

// File: rtl/spdif_transmitter.sv
// S/PDIF consumer-format transmitter: frames 16-bit stereo samples into subframes
// with validity, user, channel-status and parity bits, then line-codes them.
module spdif_transmitter
    import spdif_pkg::*;
#(
    parameter logic [31:0] CHANNEL_STATUS = DEFAULT_CHANNEL_STATUS,
    parameter logic        USER_BIT       = 1'b0
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Clk_Ena,
    input  logic        Enable,
    input  logic [15:0] Audio_Left,
    input  logic [15:0] Audio_Right,
    input  logic        Audio_Load,
    output logic        S_PDIF_Out,
    output logic        Frame_Start,
    output logic        Underrun
);

    tx_state_t  state;
    tx_state_t  next_state;
    logic [5:0] hc_cnt;
    subframe_t  subframe;
    logic [7:0] frame_cnt;

    logic [15:0] hold_left;
    logic [15:0] hold_right;
    logic        load_flag;
    logic [15:0] work_left;
    logic [15:0] work_right;
    logic        work_invalid;

    logic        at_boundary;
    logic        frame_start;
    logic        go_idle;
    logic        emit;
    logic        have_sample;

    logic [4:0]  slot;
    logic [3:0]  sample_idx;
    logic [15:0] cur_sample;
    logic        cs_bit;
    logic        parity_bit;
    logic        slot_bit;
    logic        in_preamble;
    logic [7:0]  preamble_pattern;

    // A frame boundary is the first half-cell of a left subframe; IDLE always sits there
    assign at_boundary = (hc_cnt == 6'd0) && (subframe == SUB_LEFT);
    assign frame_start = Clk_Ena && at_boundary && Enable;
    assign go_idle     = Clk_Ena && at_boundary && !Enable;
    assign emit        = Clk_Ena && (at_boundary ? Enable : (state == ST_RUN));
    assign have_sample = load_flag || Audio_Load;

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start on an enabled boundary, stop only at a boundary with Enable low
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (frame_start) next_state = ST_RUN;
            ST_RUN:  if (go_idle)     next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Half-cell, subframe and block-frame counters, cleared whenever the stream stops
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hc_cnt    <= 6'd0;
            subframe  <= SUB_LEFT;
            frame_cnt <= 8'd0;
        end else if (go_idle) begin
            hc_cnt    <= 6'd0;
            subframe  <= SUB_LEFT;
            frame_cnt <= 8'd0;
        end else if (emit) begin
            hc_cnt <= hc_cnt + 6'd1;
            if (hc_cnt == HC_LAST) begin
                if (subframe == SUB_RIGHT) begin
                    subframe  <= SUB_LEFT;
                    frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
                end else begin
                    subframe <= SUB_RIGHT;
                end
            end
        end
    end

    // Sample hand-off: holding register fed by loads, working register swapped in at
    // frame start; a missing load sends silence marked invalid
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hold_left    <= 16'd0;
            hold_right   <= 16'd0;
            load_flag    <= 1'b0;
            work_left    <= 16'd0;
            work_right   <= 16'd0;
            work_invalid <= 1'b0;
        end else begin
            if (Audio_Load) begin
                hold_left  <= Audio_Left;
                hold_right <= Audio_Right;
            end
            if (frame_start) begin
                load_flag <= 1'b0;
                if (Audio_Load) begin
                    work_left    <= Audio_Left;
                    work_right   <= Audio_Right;
                    work_invalid <= 1'b0;
                end else if (load_flag) begin
                    work_left    <= hold_left;
                    work_right   <= hold_right;
                    work_invalid <= 1'b0;
                end else begin
                    work_left    <= 16'd0;
                    work_right   <= 16'd0;
                    work_invalid <= 1'b1;
                end
            end else if (Audio_Load) begin
                load_flag <= 1'b1;
            end
        end
    end

    // Status pulses, aligned with the first half-cell appearing on the line
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Frame_Start <= 1'b0;
            Underrun    <= 1'b0;
        end else begin
            Frame_Start <= frame_start;
            Underrun    <= frame_start && !have_sample;
        end
    end

    assign slot        = hc_cnt[5:1];
    assign sample_idx  = 4'(slot - SLOT_SAMPLE_FIRST);
    assign in_preamble = (slot < SLOT_AUX_FIRST);
    assign cur_sample  = (subframe == SUB_RIGHT) ? work_right : work_left;
    assign cs_bit      = (frame_cnt < CS_DEFINED_FRAMES) ? CHANNEL_STATUS[frame_cnt[4:0]] : 1'b0;
    assign parity_bit  = ^{cur_sample, work_invalid, USER_BIT, cs_bit};

    // Bit carried by the current time slot, plus the preamble for this subframe
    always_comb begin
        slot_bit = 1'b0;
        if ((slot >= SLOT_SAMPLE_FIRST) && (slot <= SLOT_SAMPLE_LAST)) begin
            slot_bit = cur_sample[sample_idx];
        end else if (slot == SLOT_VALIDITY) begin
            slot_bit = work_invalid;
        end else if (slot == SLOT_USER) begin
            slot_bit = USER_BIT;
        end else if (slot == SLOT_CHSTAT) begin
            slot_bit = cs_bit;
        end else if (slot == SLOT_PARITY) begin
            slot_bit = parity_bit;
        end

        if (subframe == SUB_RIGHT) begin
            preamble_pattern = PREAMBLE_W;
        end else if (frame_cnt == 8'd0) begin
            preamble_pattern = PREAMBLE_B;
        end else begin
            preamble_pattern = PREAMBLE_M;
        end
    end

    biphase_mark_encoder u_encoder (
        .Clk              (Clk),
        .nReset           (nReset),
        .Clk_Ena          (emit),
        .Clear            (go_idle),
        .Bit_Value        (slot_bit),
        .Preamble         (in_preamble),
        .Preamble_Pattern (preamble_pattern),
        .Line_Out         (S_PDIF_Out)
    );

endmodule

// File: tb/tb_spdif_transmitter.sv
// Directed bench for spdif_transmitter: captures every half-cell of each frame and
// compares it against subframes built from the sample values sent.
module tb_spdif_transmitter;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    logic        Clk;
    logic        nReset;
    logic        Clk_Ena;
    logic        Enable;
    logic [15:0] Audio_Left;
    logic [15:0] Audio_Right;
    logic        Audio_Load;
    logic        S_PDIF_Out;
    logic        Frame_Start;
    logic        Underrun;

    int   compared;
    int   mismatched;
    logic lvl;

    spdif_transmitter dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .Clk_Ena     (Clk_Ena),
        .Enable      (Enable),
        .Audio_Left  (Audio_Left),
        .Audio_Right (Audio_Right),
        .Audio_Load  (Audio_Load),
        .S_PDIF_Out  (S_PDIF_Out),
        .Frame_Start (Frame_Start),
        .Underrun    (Underrun)
    );

    // 50 MHz system clock
    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Channel-status bit for block frame f with the 32'h0200_0004 default word
    function automatic logic csBit(input int f);
        return (f == 2) || (f == 25);
    endfunction

    // Expected 64 half-cells of one subframe, first half-cell in bit 63
    function automatic logic [63:0] expSub(input logic [7:0] pre, input logic startLvl,
                                           input logic [15:0] smp, input logic v, input logic c);
        logic [31:0] slots;
        logic [63:0] hc;
        logic        level;
        slots = '0;
        for (int i = 0; i < 16; i++) slots[12 + i] = smp[i];
        slots[28] = v;
        slots[29] = 1'b0;
        slots[30] = c;
        slots[31] = ^slots[30:4];
        hc = '0;
        for (int k = 0; k < 8; k++) hc[63 - k] = pre[7 - k] ^ startLvl;
        level = hc[56];
        for (int s = 4; s < 32; s++) begin
            level = ~level;
            hc[63 - 2 * s] = level;
            if (slots[s]) level = ~level;
            hc[62 - 2 * s] = level;
        end
        return hc;
    endfunction

    // Drive Clk_Ena pulses while the transmitter should stay silent
    task automatic pulseIdle(input int n, output int highs, output int starts);
        highs  = 0;
        starts = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Clk_Ena = 1'b1;
            @(negedge Clk);
            Clk_Ena = 1'b0;
            if (S_PDIF_Out) highs++;
            if (Frame_Start || Underrun) starts++;
        end
    endtask

    // loadMode: 0 none, 1 one load before, 2 two loads before (last wins), 3 load with frame start
    task automatic applyStimulus(input int loadMode, input logic [15:0] l, input logic [15:0] r,
                                 input int nCells, input int dropAt, output logic [127:0] frame,
                                 output int fsCount, output int urCount,
                                 output logic firstFs, output logic firstUr);
        frame   = '0;
        fsCount = 0;
        urCount = 0;
        firstFs = 1'b0;
        firstUr = 1'b0;
        if (loadMode == 2) begin
            @(negedge Clk);
            Audio_Left  = 16'hDEAD;
            Audio_Right = 16'hBEEF;
            Audio_Load  = 1'b1;
            @(negedge Clk);
            Audio_Load  = 1'b0;
        end
        if (loadMode == 1 || loadMode == 2) begin
            @(negedge Clk);
            Audio_Left  = l;
            Audio_Right = r;
            Audio_Load  = 1'b1;
            @(negedge Clk);
            Audio_Load  = 1'b0;
        end
        for (int h = 0; h < nCells; h++) begin
            @(negedge Clk);
            Clk_Ena = 1'b1;
            if (h == 0 && loadMode == 3) begin
                Audio_Left  = l;
                Audio_Right = r;
                Audio_Load  = 1'b1;
            end
            if (h == dropAt) Enable = 1'b0;
            @(negedge Clk);
            Clk_Ena    = 1'b0;
            Audio_Load = 1'b0;
            frame[127 - h] = S_PDIF_Out;
            if (Frame_Start) fsCount++;
            if (Underrun) urCount++;
            if (h == 0) begin
                firstFs = Frame_Start;
                firstUr = Underrun;
            end
        end
    endtask

    // One complete frame plus its standard comparisons; bf is the frame index in the block
    task automatic checkFrame(input string tag, input int mode, input logic [15:0] l,
                              input logic [15:0] r, input int dropAt, input int bf,
                              output logic [127:0] frame);
        int          fsCount;
        int          urCount;
        logic        firstFs;
        logic        firstUr;
        logic        uf;
        logic [63:0] expL;
        logic [63:0] expR;
        applyStimulus(mode, l, r, 128, dropAt, frame, fsCount, urCount, firstFs, firstUr);
        uf   = (mode == 0);
        expL = expSub((bf == 0) ? PRE_B : PRE_M, lvl, uf ? 16'h0000 : l, uf, csBit(bf));
        lvl  = expL[0];
        expR = expSub(PRE_W, lvl, uf ? 16'h0000 : r, uf, csBit(bf));
        lvl  = expR[0];
        checkOutput({tag, "_left"}, frame[127:64], expL);
        checkOutput({tag, "_right"}, frame[63:0], expR);
        checkOutput({tag, "_fs_first"}, 64'(firstFs), 64'd1);
        checkOutput({tag, "_fs_count"}, 64'(fsCount), 64'd1);
        checkOutput({tag, "_ur_first"}, 64'(firstUr), 64'(uf));
        checkOutput({tag, "_ur_count"}, 64'(urCount), uf ? 64'd1 : 64'd0);
    endtask

    initial begin
        logic [127:0] frame;
        logic [15:0]  l;
        logic [15:0]  r;
        int           mode;
        int           highs;
        int           starts;
        int           fsCount;
        int           urCount;
        logic         firstFs;
        logic         firstUr;

        compared    = 0;
        mismatched  = 0;
        lvl         = 1'b0;
        nReset      = 1'b0;
        Clk_Ena     = 1'b0;
        Enable      = 1'b0;
        Audio_Load  = 1'b0;
        Audio_Left  = 16'h0000;
        Audio_Right = 16'h0000;

        // Reset state
        repeat (3) @(negedge Clk);
        checkOutput("reset_line", 64'(S_PDIF_Out), 64'd0);
        checkOutput("reset_fs", 64'(Frame_Start), 64'd0);
        checkOutput("reset_ur", 64'(Underrun), 64'd0);
        nReset = 1'b1;

        // Clk_Ena with Enable low must not start anything
        pulseIdle(6, highs, starts);
        checkOutput("idle_line", 64'(highs), 64'd0);
        checkOutput("idle_starts", 64'(starts), 64'd0);

        // 193 frames: block wrap, underrun at 40, double load at 41, coincident load at 42
        Enable = 1'b1;
        for (int f = 0; f < 193; f++) begin
            mode = 1;
            if (f == 40) mode = 0;
            if (f == 41) mode = 2;
            if (f == 42) mode = 3;
            l = (f == 0) ? 16'h0001 : (16'h5A5A ^ 16'(f * 613));
            r = (f == 0) ? 16'h0000 : (16'hC3C3 ^ 16'(f * 37));
            checkFrame($sformatf("f%0d", f), mode, l, r, -1, f % 192, frame);
            if (f == 0) begin
                checkOutput("f0_pre_B", 64'(frame[127:120]), 64'(8'b11101000));
                checkOutput("f0_slot12_mid", 64'(frame[103] ^ frame[102]), 64'd1);
                checkOutput("f0_left_P", 64'(frame[65] ^ frame[64]), 64'd1);
                checkOutput("f0_right_P", 64'(frame[1] ^ frame[0]), 64'd0);
                checkOutput("f0_left_end", 64'(frame[64]), 64'd0);
                checkOutput("f0_right_end", 64'(frame[0]), 64'd0);
            end
            if (f == 1) begin
                checkOutput("f1_pre_M", 64'(frame[127:120]), 64'(8'b11100010));
                checkOutput("f1_pre_W", 64'(frame[63:56]), 64'(8'b11100100));
            end
            if (f == 2 || f == 25) begin
                checkOutput($sformatf("f%0d_C_left", f), 64'(frame[67] ^ frame[66]), 64'd1);
                checkOutput($sformatf("f%0d_C_right", f), 64'(frame[3] ^ frame[2]), 64'd1);
            end
            if (f == 3 || f == 32 || f == 100) begin
                checkOutput($sformatf("f%0d_C_left", f), 64'(frame[67] ^ frame[66]), 64'd0);
            end
            if (f == 40) begin
                checkOutput("f40_V_left", 64'(frame[71] ^ frame[70]), 64'd1);
                checkOutput("f40_V_right", 64'(frame[7] ^ frame[6]), 64'd1);
            end
            if (f == 41) begin
                checkOutput("f41_V_left", 64'(frame[71] ^ frame[70]), 64'd0);
            end
            if (f == 192) begin
                checkOutput("f192_pre_B", 64'(frame[127:120]), 64'(8'b11101000));
            end
        end

        // Partial frame (block frame 1), then a load, then reset at half-cell 20
        applyStimulus(1, 16'h1234, 16'h5678, 21, -1, frame, fsCount, urCount, firstFs, firstUr);
        checkOutput("partial_fs_first", 64'(firstFs), 64'd1);
        checkOutput("partial_pre_M", 64'(frame[127:120]), 64'(8'b11100010));
        checkOutput("hc20_level", 64'(S_PDIF_Out), 64'd1);
        @(negedge Clk);
        Audio_Left  = 16'hAAAA;
        Audio_Right = 16'h5555;
        Audio_Load  = 1'b1;
        @(negedge Clk);
        Audio_Load  = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("hold_between_ena", 64'(S_PDIF_Out), 64'd1);
        checkOutput("hold_fs", 64'(Frame_Start), 64'd0);
        #3;
        nReset = 1'b0;
        #1;
        checkOutput("async_reset_line", 64'(S_PDIF_Out), 64'd0);
        @(negedge Clk);
        nReset = 1'b1;
        lvl    = 1'b0;

        // After reset: load flag is gone (underrun), block restarts at frame 0
        checkFrame("rst_f0", 0, 16'h0000, 16'h0000, -1, 0, frame);
        checkOutput("rst_f0_pre_B", 64'(frame[127:120]), 64'(8'b11101000));
        checkFrame("rst_f1", 1, 16'h8000, 16'h7FFF, -1, 1, frame);

        // Enable drops mid-frame: the frame completes, then the line stays low
        checkFrame("drop_f2", 1, 16'hFFFF, 16'h0000, 30, 2, frame);
        pulseIdle(6, highs, starts);
        checkOutput("after_drop_line", 64'(highs), 64'd0);
        checkOutput("after_drop_starts", 64'(starts), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spdif_transmitter.md
Name: spdif_transmitter

Overview:
- Generates an IEC 60958 consumer S/PDIF stream on S_PDIF_Out from the 16-bit stereo samples the USB audio path already delivers at 48 kHz.
- Sits beside the PWM path and is fed the same left/right audio words.
- Builds the frame structure, 192-frame channel-status blocks and parity, then biphase-mark encodes the result.
- Bit timing comes from a half-cell clock enable supplied by the existing clock recovery, so the block is rate-agnostic.

Parameters:
CHANNEL_STATUS, 32'h0200_0004, channel-status bits 0..31; bit 2 = copy permitted, bit 25 = 48 kHz code; bits 32..191 are transmitted as 0
USER_BIT, 1'b0, constant U bit value

Ports:
Clk  input  1  system clock (50 MHz)
nReset  input  1  reset; one clock; reset is asynchronous and active-low
Clk_Ena  input  1  one-cycle pulse per biphase half-cell (128 per sample period; 6.144 MHz at 48 kHz)
Enable  input  1  stream enable, sampled at frame boundaries
Audio_Left  input  16  left sample, two's complement
Audio_Right  input  16  right sample, two's complement
Audio_Load  input  1  one-cycle strobe; latches both samples into the holding register
S_PDIF_Out  output  1  biphase-mark encoded stream, registered
Frame_Start  output  1  one-cycle pulse when a frame's first half-cell is driven
Underrun  output  1  one-cycle pulse when a frame starts with no load since the previous frame start

Behaviour:
- Reset values: S_PDIF_Out=0, Frame_Start=0, Underrun=0, holding register=0, load flag=0, half-cell counter=0, subframe=left, frame counter=0, line level=0. Reset mid-frame aborts the frame immediately.
- States:
  - IDLE: output held 0, counters cleared to block start. Leaves on a Clk_Ena with Enable=1.
  - RUN: from IDLE entry, the first frame is frame 0 of a block.
  - RUN -> IDLE only when Enable=0 is sampled at a frame boundary. A partial frame is never emitted.
- Counters:
  - Only Clk_Ena advances state; everything between pulses is held.
  - Half-cell counter runs 0..63 per subframe: left subframe, then right subframe.
  - Frame counter runs 0..191, wraps to 0, and advances after each right subframe.
- Frame start (first Clk_Ena of a left subframe):
  - If the load flag is set: copy the holding register to the working register and clear the flag.
  - Otherwise: working data = 0, V = 1 for both subframes, and Underrun pulses on the same cycle as Frame_Start.
  - An Audio_Load coinciding with the frame start is used for that frame.
- Subframe time slots:
  - 0..3: preamble.
  - 4..11: 0.
  - 12..27: sample, LSB first.
  - 28: V (0 = valid).
  - 29: USER_BIT.
  - 30: C = channel-status bit [frame counter] (CHANNEL_STATUS for 0..31, else 0), same value in both subframes.
  - 31: P = even parity over slots 4..30.
- Preambles, as 8 half-cells, are XORed with the current line level:
  - B = 11101000 on left subframe of frame 0.
  - M = 11100010 on other left subframes.
  - W = 11100100 on right subframes.
- Data slots 4..31 use biphase-mark coding: toggle at every cell start, toggle again at mid-cell when the bit is 1.
- Latency: S_PDIF_Out updates the Clk cycle after each Clk_Ena. Frame_Start is coincident with the first half-cell of a frame.
- Boundary cases:
  - A second Audio_Load before a frame start overwrites the holding register (last write wins).
  - Clk_Ena while Enable=0 in IDLE has no effect.

Decomposition:
- Package spdif_pkg: preamble constants (B/M/W), SUBFRAME_HALFCELLS=64, BLOCK_FRAMES=192, default channel-status word, slot index constants.
- One sub-module, biphase_mark_encoder:
  - Inputs: Clk, nReset, Clk_Ena, bit value, preamble flag with 8-bit pattern.
  - Owns the line-level register and half-cell phase.
  - Keeps framing separate from line coding.

Test Plan:
1. Reset, Enable=1, load 0/0 before each frame -> first 8 half-cells 11101000 (B). Frame_Start every 128 Clk_Ena. No Underrun.
2. Left=16'h0001, Right=0 in frame 0 -> left slot 12 shows a mid-cell toggle; P=1; right subframe P=0. Line level at end of each subframe equals the level at its start.
3. 193 frames with loads each frame -> B on frames 0 and 192, M on other left subframes, W on all right subframes.
4. Default CHANNEL_STATUS -> C=1 only in frames 2 and 25 (both subframes), 0 elsewhere including frames 32..191.
5. Skip one Audio_Load -> Underrun pulses once with Frame_Start; that frame carries 0 data, V=1, correct parity. The next loaded frame has V=0.
6. Assert nReset mid-frame at half-cell 20 -> S_PDIF_Out=0 asynchronously. After release, the first frame is B / frame 0. Enable dropped mid-frame -> current frame completes, then output holds 0.
